vend_dispense_ctrl: RTL and testbench
=====================================

# vend_dispense_ctrl

Downstream stage of the vending FSM. Captures its one-cycle `out` (vend) and `change` (refund code) outputs into a small event queue, then drives the product motor and the coin-return hopper, confirming each action against sensor feedback with timeouts. It sits between the vending FSM and the physical actuators, so the FSM never stalls on slow mechanics.

## Interface
- `MOTOR_TIMEOUT`, 1000: max cycles `motor_en` stays high waiting for `product_sensor`.
- `PULSE_W`, 4: width in cycles of each `hopper_pulse`.
- `COIN_TIMEOUT`, 200: max cycles waiting for `coin_sensor` after a hopper pulse.
- `QDEPTH`, 4: event queue depth (power of 2, ≥2).
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `out`  in  1  vend request from vending FSM, 1-cycle pulse.
- `change`  in  2  refund code from vending FSM: 00 none, 01 one coin, 10 two coins, 11 invalid.
- `product_sensor`  in  1  product-drop detect, already synchronised, level high.
- `coin_sensor`  in  1  coin-ejected detect, already synchronised, level high.
- `motor_en`  out  1  product motor drive.
- `hopper_pulse`  out  1  coin hopper eject strobe.
- `busy`  out  1  high when state ≠ IDLE or queue non-empty.
- `vend_done`  out  1  1-cycle pulse when an event finishes.
- `queue_count`  out  $clog2(QDEPTH)+1  occupied queue entries.
- `fault_vend`  out  1  sticky: motor timeout occurred.
- `fault_coin`  out  1  sticky: coin timeout occurred.
- `overflow`  out  1  sticky: event dropped on full queue.

## Operation
- Capture: each cycle with `out`=1 or `change`∈{01,10} pushes one entry {vend=`out`, coins=0/1/2}. `change`=11 counts as 0 coins; if `out`=0 too, nothing is pushed.
- Queue is FIFO. If full and no pop that cycle: entry dropped, `overflow` set. Push and pop in the same cycle on a full queue: push accepted, count unchanged.
- States: IDLE, VEND, PULSE, WAIT_COIN, DONE.
- IDLE: if queue non-empty, pop head. Next state VEND if vend=1, else PULSE if coins>0, else DONE.
- VEND: `motor_en`=1, cycle counter runs. `product_sensor`=1 → leave. Counter reaching MOTOR_TIMEOUT → set `fault_vend` and leave. Leave to PULSE if coins>0, else DONE.
- PULSE: `hopper_pulse`=1 for exactly PULSE_W cycles, then WAIT_COIN.
- WAIT_COIN: `coin_sensor`=1 → decrement coins, then PULSE if coins remain, else DONE. COIN_TIMEOUT cycles without sensor → set `fault_coin`, discard remaining coins of this entry, go to DONE. `coin_sensor` during PULSE is ignored.
- DONE: `vend_done`=1 for one cycle, then IDLE.
- Sticky faults and `overflow` clear only on `rst`. Faults never block later entries.
- `product_sensor` is ignored outside VEND.

## Timing
- Reset: state IDLE, queue empty, `queue_count`=0. All outputs 0: `motor_en`, `hopper_pulse`, `busy`, `vend_done`, `fault_vend`, `fault_coin`, `overflow`.
- Reset mid-operation: actuators drop the cycle after the reset edge, and queued events are lost.
- All outputs are registered.
- `out` high at edge E0 → `queue_count`=1 after E0; pop at E1; `motor_en` high after E1 (2-cycle latency from idle).
- `motor_en` high for n+1 cycles when `product_sensor` is first seen n cycles after motor start, capped at MOTOR_TIMEOUT cycles.
- After a coin is confirmed, the next `hopper_pulse` rises the following cycle.
- DONE→IDLE→pop adds 2 cycles between back-to-back events.
- `busy` is high from the cycle after a push until the cycle after DONE with an empty queue.

## Test plan
- Single vend: `out` pulse, `product_sensor` 5 cycles after `motor_en` rises → `motor_en` high 6 cycles, no hopper activity, one `vend_done`, no faults.
- Refund two coins: `change`=10, `coin_sensor` 3 cycles after each pulse falls → two 4-cycle `hopper_pulse`s, one `vend_done`, `queue_count` returns to 0.
- Vend plus change (`out`=1, `change`=01 same cycle) → single entry: motor phase, then one hopper pulse, then one `vend_done`.
- Motor timeout: `out`, `product_sensor` never asserted → `motor_en` high exactly 1000 cycles, `fault_vend`=1, `vend_done` pulses; next event still serviced.
- Overflow: 6 `out` pulses on consecutive cycles while sensors idle → 4 queued (1 popped), `overflow`=1; the remaining events complete in order.
- Reset mid-PULSE with 2 entries queued → after reset edge `hopper_pulse`=0, `queue_count`=0, `busy`=0, sticky flags cleared.

Source files
------------

// File: rtl/vend_dispense_ctrl_if.sv
// Connection bundle for vend_dispense_ctrl: vending-FSM events, sensor feedback,
// actuator drives and status flags.
interface vend_dispense_ctrl_if #(
   parameter int QDEPTH = 4
);
   logic                    out;
   logic [1:0]              change;
   logic                    product_sensor;
   logic                    coin_sensor;
   logic                    motor_en;
   logic                    hopper_pulse;
   logic                    busy;
   logic                    vend_done;
   logic [$clog2(QDEPTH):0] queue_count;
   logic                    fault_vend;
   logic                    fault_coin;
   logic                    overflow;

   modport master (
      output out, change, product_sensor, coin_sensor,
      input  motor_en, hopper_pulse, busy, vend_done, queue_count,
             fault_vend, fault_coin, overflow
   );

   modport slave (
      input  out, change, product_sensor, coin_sensor,
      output motor_en, hopper_pulse, busy, vend_done, queue_count,
             fault_vend, fault_coin, overflow
   );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Buffers vend/refund events from the vending FSM and sequences the product motor
// and coin hopper, confirming each action against sensors with timeouts.
module vend_dispense_ctrl #(
   parameter int MOTOR_TIMEOUT = 1000,
   parameter int PULSE_W       = 4,
   parameter int COIN_TIMEOUT  = 200,
   parameter int QDEPTH        = 4
) (
   input logic                 clk,
   input logic                 rst,
   vend_dispense_ctrl_if.slave bus
);
   localparam int AW   = $clog2(QDEPTH);
   localparam int CW   = AW + 1;
   localparam int TMAX = (MOTOR_TIMEOUT > COIN_TIMEOUT)
                         ? ((MOTOR_TIMEOUT > PULSE_W) ? MOTOR_TIMEOUT : PULSE_W)
                         : ((COIN_TIMEOUT > PULSE_W) ? COIN_TIMEOUT : PULSE_W);
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_VEND      = 3'd1,
      S_PULSE     = 3'd2,
      S_WAIT_COIN = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   typedef struct packed {
      logic       vend;
      logic [1:0] coins;
   } entry_t;

   entry_t          mem_r [QDEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic [CW-1:0]   count_n;

   entry_t          in_entry_s;
   entry_t          head_s;
   logic            push_s;
   logic            pop_s;
   logic            full_s;
   logic            push_ok_s;
   logic            drop_s;

   state_t          state_r;
   state_t          state_n;
   logic [TW-1:0]   tmr_r;
   logic [TW-1:0]   tmr_n;
   logic [1:0]      coins_r;
   logic [1:0]      coins_n;
   logic            fault_vend_r;
   logic            fault_vend_n;
   logic            fault_coin_r;
   logic            fault_coin_n;

   logic            motor_en_r;
   logic            hopper_pulse_r;
   logic            vend_done_r;
   logic            busy_r;
   logic            overflow_r;

   // Decode the incoming event; an invalid refund code carries no coins.
   always_comb begin
      in_entry_s.vend = bus.out;
      case (bus.change)
         2'b01:   in_entry_s.coins = 2'd1;
         2'b10:   in_entry_s.coins = 2'd2;
         default: in_entry_s.coins = 2'd0;
      endcase
      push_s = bus.out | (in_entry_s.coins != 2'd0);
   end

   assign head_s    = mem_r[rd_ptr_r];
   assign full_s    = (count_r == CW'(QDEPTH));
   assign pop_s     = (state_r == S_IDLE) && (count_r != CW'(0));
   assign push_ok_s = push_s && (!full_s || pop_s);
   assign drop_s    = push_s && full_s && !pop_s;

   // Queue occupancy after this cycle's push/pop.
   always_comb begin
      count_n = count_r;
      case ({push_ok_s, pop_s})
         2'b10:   count_n = count_r + CW'(1);
         2'b01:   count_n = count_r - CW'(1);
         default: count_n = count_r;
      endcase
   end

   // Event storage; contents are don't-care once the pointers are reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= in_entry_s;
      end
   end

   // Queue pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_n;
      end
   end

   // Sequencer state, shared phase timer, pending coins and sticky faults.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= S_IDLE;
         tmr_r        <= '0;
         coins_r      <= 2'd0;
         fault_vend_r <= 1'b0;
         fault_coin_r <= 1'b0;
      end else begin
         state_r      <= state_n;
         tmr_r        <= tmr_n;
         coins_r      <= coins_n;
         fault_vend_r <= fault_vend_n;
         fault_coin_r <= fault_coin_n;
      end
   end

   // Next-state logic; the timer restarts from zero on every phase change.
   always_comb begin
      state_n      = state_r;
      tmr_n        = tmr_r;
      coins_n      = coins_r;
      fault_vend_n = fault_vend_r;
      fault_coin_n = fault_coin_r;
      case (state_r)
         S_IDLE: begin
            if (pop_s) begin
               coins_n = head_s.coins;
               tmr_n   = '0;
               if (head_s.vend) begin
                  state_n = S_VEND;
               end else if (head_s.coins != 2'd0) begin
                  state_n = S_PULSE;
               end else begin
                  state_n = S_DONE;
               end
            end else begin
               state_n = S_IDLE;
            end
         end
         S_VEND: begin
            if (bus.product_sensor || (tmr_r == TW'(MOTOR_TIMEOUT - 1))) begin
               // A drop seen on the last allowed cycle still counts as success.
               if (!bus.product_sensor) begin
                  fault_vend_n = 1'b1;
               end else begin
                  fault_vend_n = fault_vend_r;
               end
               tmr_n   = '0;
               state_n = (coins_r != 2'd0) ? S_PULSE : S_DONE;
            end else begin
               tmr_n = tmr_r + TW'(1);
            end
         end
         S_PULSE: begin
            if (tmr_r == TW'(PULSE_W - 1)) begin
               tmr_n   = '0;
               state_n = S_WAIT_COIN;
            end else begin
               tmr_n = tmr_r + TW'(1);
            end
         end
         S_WAIT_COIN: begin
            if (bus.coin_sensor) begin
               coins_n = coins_r - 2'd1;
               tmr_n   = '0;
               state_n = (coins_r > 2'd1) ? S_PULSE : S_DONE;
            end else if (tmr_r == TW'(COIN_TIMEOUT - 1)) begin
               fault_coin_n = 1'b1;
               coins_n      = 2'd0;
               tmr_n        = '0;
               state_n      = S_DONE;
            end else begin
               tmr_n = tmr_r + TW'(1);
            end
         end
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
            tmr_n   = '0;
            coins_n = 2'd0;
         end
      endcase
   end

   // Outputs are registered from the next state so they align with the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         motor_en_r     <= 1'b0;
         hopper_pulse_r <= 1'b0;
         vend_done_r    <= 1'b0;
         busy_r         <= 1'b0;
         overflow_r     <= 1'b0;
      end else begin
         motor_en_r     <= (state_n == S_VEND);
         hopper_pulse_r <= (state_n == S_PULSE);
         vend_done_r    <= (state_n == S_DONE);
         busy_r         <= (state_n != S_IDLE) || (count_n != CW'(0));
         overflow_r     <= overflow_r | drop_s;
      end
   end

   assign bus.motor_en     = motor_en_r;
   assign bus.hopper_pulse = hopper_pulse_r;
   assign bus.vend_done    = vend_done_r;
   assign bus.busy         = busy_r;
   assign bus.queue_count  = count_r;
   assign bus.fault_vend   = fault_vend_r;
   assign bus.fault_coin   = fault_coin_r;
   assign bus.overflow     = overflow_r;
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: sensor responders, an event scoreboard
// checked at each vend_done, and direct flag/counter checks between steps.
module tb_vend_dispense_ctrl;
   localparam int MT = 1000;
   localparam int PW = 4;
   localparam int CT = 200;
   localparam int QD = 4;

   typedef struct {
      int   motor;
      int   pulses;
      logic fv;
      logic fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   prod_delay = 5;
   int   coin_delay = 3;
   logic fv_m = 1'b0;
   logic fc_m = 1'b0;
   exp_t sb[$];

   int   motor_cyc = 0;
   int   pulse_cnt = 0;
   int   hp_width  = 0;
   logic hp_prev   = 1'b0;

   vend_dispense_ctrl_if #(.QDEPTH(QD)) bus ();

   vend_dispense_ctrl #(
      .MOTOR_TIMEOUT(MT),
      .PULSE_W(PW),
      .COIN_TIMEOUT(CT),
      .QDEPTH(QD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Expected outcome of one accepted event, given the current sensor delays.
   task automatic push_exp(input logic o, input logic [1:0] ch);
      exp_t e;
      int   n;
      n = (ch == 2'b01) ? 1 : ((ch == 2'b10) ? 2 : 0);
      e.motor  = o ? ((prod_delay < 0) ? MT : prod_delay + 1) : 0;
      e.pulses = (n == 0) ? 0 : ((coin_delay < 0) ? 1 : n);
      fv_m = fv_m | (o && (prod_delay < 0));
      fc_m = fc_m | ((n > 0) && (coin_delay < 0));
      e.fv = fv_m;
      e.fc = fc_m;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic o, input logic [1:0] ch);
      bus.out    = o;
      bus.change = ch;
      tick(1);
      bus.out    = 1'b0;
      bus.change = 2'b00;
   endtask

   task automatic wait_idle(input int max_cyc);
      int k;
      k = 0;
      while ((bus.busy !== 1'b0) && (k < max_cyc)) begin
         tick(1);
         k++;
      end
      check("idle_reached", bus.busy, 1'b0);
   endtask

   // Product sensor: pulses during motor cycle prod_delay (never if negative).
   initial begin : prod_resp
      int k;
      k = 0;
      bus.product_sensor = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.motor_en === 1'b1) begin
            bus.product_sensor = (prod_delay >= 0) && (k == prod_delay);
            k++;
         end else begin
            bus.product_sensor = 1'b0;
            k = 0;
         end
      end
   end

   // Coin sensor: pulses coin_delay cycles after each hopper pulse falls.
   initial begin : coin_resp
      int   j;
      logic prev;
      j = -1;
      prev = 1'b0;
      bus.coin_sensor = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.hopper_pulse === 1'b1) begin
            j = -1;
            bus.coin_sensor = 1'b0;
         end else begin
            if (prev) begin
               j = 0;
            end else if (j >= 0) begin
               j++;
            end
            bus.coin_sensor = (coin_delay >= 0) && (j == coin_delay);
         end
         prev = bus.hopper_pulse;
      end
   end

   // Per-event activity monitor, scored against the expectation queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst === 1'b1) begin
         motor_cyc = 0;
         pulse_cnt = 0;
         hp_width  = 0;
         hp_prev   = 1'b0;
      end else begin
         if (bus.motor_en === 1'b1) motor_cyc++;
         if (bus.hopper_pulse === 1'b1) begin
            if (!hp_prev) pulse_cnt++;
            hp_width++;
         end else if (hp_prev) begin
            check("hopper_width", hp_width, PW);
            hp_width = 0;
         end
         hp_prev = bus.hopper_pulse;
         if (bus.vend_done === 1'b1) begin
            check("sb_nonempty", (sb.size() > 0), 1'b1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("motor_cycles", motor_cyc, e.motor);
               check("hopper_pulses", pulse_cnt, e.pulses);
               check("fault_vend_at_done", bus.fault_vend, e.fv);
               check("fault_coin_at_done", bus.fault_coin, e.fc);
            end
            motor_cyc = 0;
            pulse_cnt = 0;
         end
      end
   end

   initial begin
      rst        = 1'b1;
      bus.out    = 1'b0;
      bus.change = 2'b00;
      tick(3);
      check("rst_motor_en", bus.motor_en, 1'b0);
      check("rst_hopper", bus.hopper_pulse, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_vend_done", bus.vend_done, 1'b0);
      check("rst_queue_count", bus.queue_count, 0);
      check("rst_faults", {bus.fault_vend, bus.fault_coin, bus.overflow}, 3'b000);
      rst = 1'b0;
      tick(2);

      // single vend with 2-cycle motor latency
      push_exp(1'b1, 2'b00);
      send(1'b1, 2'b00);
      check("vend_qcount_after_push", bus.queue_count, 1);
      check("vend_busy_after_push", bus.busy, 1'b1);
      check("vend_motor_not_yet", bus.motor_en, 1'b0);
      tick(1);
      check("vend_motor_on", bus.motor_en, 1'b1);
      check("vend_qcount_after_pop", bus.queue_count, 0);
      wait_idle(100);
      check("vend_no_faults", {bus.fault_vend, bus.fault_coin}, 2'b00);

      // refund two coins
      push_exp(1'b0, 2'b10);
      send(1'b0, 2'b10);
      wait_idle(200);
      check("refund_qcount", bus.queue_count, 0);

      // vend plus one coin as a single entry
      push_exp(1'b1, 2'b01);
      send(1'b1, 2'b01);
      check("combo_single_entry", bus.queue_count, 1);
      wait_idle(200);

      // invalid refund code alone pushes nothing
      send(1'b0, 2'b11);
      check("invalid_code_no_push", bus.queue_count, 0);
      check("invalid_code_idle", bus.busy, 1'b0);

      // coin timeout discards the second coin
      coin_delay = -1;
      push_exp(1'b0, 2'b10);
      send(1'b0, 2'b10);
      wait_idle(CT + 100);
      check("coin_timeout_fault", bus.fault_coin, 1'b1);
      coin_delay = 3;

      // motor timeout, then a later event is still serviced
      prod_delay = -1;
      push_exp(1'b1, 2'b00);
      send(1'b1, 2'b00);
      wait_idle(MT + 100);
      check("motor_timeout_fault", bus.fault_vend, 1'b1);
      prod_delay = 5;
      push_exp(1'b1, 2'b00);
      send(1'b1, 2'b00);
      wait_idle(100);

      // six back-to-back events: one popped, four queued, one dropped
      prod_delay = 20;
      coin_delay = 2;
      begin
         logic [1:0] pat [6];
         pat = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
         for (int i = 0; i < 6; i++) begin
            if (i < 5) push_exp(1'b1, pat[i]);
            bus.out    = 1'b1;
            bus.change = pat[i];
            tick(1);
         end
         bus.out    = 1'b0;
         bus.change = 2'b00;
      end
      check("ovf_qcount_full", bus.queue_count, QD);
      check("ovf_flag", bus.overflow, 1'b1);
      wait_idle(1000);
      check("ovf_drained", bus.queue_count, 0);

      // reset during a hopper pulse with two entries queued
      prod_delay = 5;
      coin_delay = 3;
      push_exp(1'b0, 2'b01);
      send(1'b0, 2'b01);
      push_exp(1'b1, 2'b00);
      send(1'b1, 2'b00);
      push_exp(1'b1, 2'b00);
      send(1'b1, 2'b00);
      check("pre_rst_hopper", bus.hopper_pulse, 1'b1);
      check("pre_rst_qcount", bus.queue_count, 2);
      check("pre_rst_sticky", {bus.fault_vend, bus.fault_coin, bus.overflow}, 3'b111);
      rst = 1'b1;
      sb.delete();
      fv_m = 1'b0;
      fc_m = 1'b0;
      tick(1);
      check("mid_rst_hopper", bus.hopper_pulse, 1'b0);
      check("mid_rst_qcount", bus.queue_count, 0);
      check("mid_rst_busy", bus.busy, 1'b0);
      check("mid_rst_sticky", {bus.fault_vend, bus.fault_coin, bus.overflow}, 3'b000);
      rst = 1'b0;
      tick(2);

      // service resumes cleanly after reset
      push_exp(1'b1, 2'b01);
      send(1'b1, 2'b01);
      wait_idle(200);
      tick(2);
      check("sb_empty_at_end", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
